// File: rtl/router_pkt_ctrl.sv
// Packet-reception FSM for the 1x3 router.
// Sequences header, payload, full stall, parity and drop.
module router_pkt_ctrl #(
  parameter int WAIT_LIMIT = 64,
  parameter int CNT_W      = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       write_en_reg,
  output logic       rst_int_reg,
  output logic       busy,
  output logic       pkt_drop
);

  typedef enum logic [2:0] {
    S_DA, S_LFD, S_LD, S_FFS,
    S_LAF, S_LP, S_CPE, S_WTE
  } state_e;

  localparam logic [CNT_W-1:0] LIM_M1 =
    CNT_W'(WAIT_LIMIT - 1);

  state_e           state_q, state_d;
  logic [1:0]       addr_q, addr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             drop_q, drop_d;

  logic [3:0] empty_v;
  logic [3:0] srst_v;
  logic       sel_empty;
  logic       sel_srst;
  logic       in_empty;
  logic       hdr_ok;

  assign empty_v = {1'b0, fifo_empty_2,
                    fifo_empty_1, fifo_empty_0};
  assign srst_v  = {1'b0, soft_reset_2,
                    soft_reset_1, soft_reset_0};
  assign sel_empty = empty_v[addr_q];
  assign sel_srst  = srst_v[addr_q];
  assign in_empty  = empty_v[data_in];
  assign hdr_ok    = pkt_valid && (data_in != 2'b11);

  // Next-state, address latch, wait counter and drop pulse.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = '0;
    drop_d  = 1'b0;
    if (state_q != S_DA && sel_srst) begin
      state_d = S_DA;
      drop_d  = 1'b1;
    end else begin
      unique case (state_q)
        S_DA: begin
          if (hdr_ok) begin
            addr_d  = data_in;
            state_d = in_empty ? S_LFD : S_WTE;
          end
        end
        S_LFD: state_d = S_LD;
        S_LD: begin
          if (fifo_full)       state_d = S_FFS;
          else if (!pkt_valid) state_d = S_LP;
        end
        S_FFS: begin
          if (!fifo_full) state_d = S_LAF;
        end
        S_LAF: begin
          if (parity_done)        state_d = S_DA;
          else if (low_pkt_valid) state_d = S_LP;
          else                    state_d = S_LD;
        end
        S_LP: state_d = S_CPE;
        S_CPE: state_d = fifo_full ? S_FFS : S_DA;
        S_WTE: begin
          if (sel_empty) begin
            state_d = S_LFD;
          end else if (WAIT_LIMIT != 0 &&
                       cnt_q == LIM_M1) begin
            state_d = S_DA;
            drop_d  = 1'b1;
          end else if (&cnt_q) begin
            cnt_d = cnt_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = S_DA;
      endcase
    end
  end

  // State, address, counter and drop registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_DA;
      addr_q  <= 2'b00;
      cnt_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
    end
  end

  assign detect_add   = (state_q == S_DA);
  assign lfd_state    = (state_q == S_LFD);
  assign ld_state     = (state_q == S_LD);
  assign laf_state    = (state_q == S_LAF);
  assign full_state   = (state_q == S_FFS);
  assign rst_int_reg  = (state_q == S_CPE);
  assign write_en_reg = (state_q == S_LFD) ||
                        (state_q == S_LD)  ||
                        (state_q == S_LAF) ||
                        (state_q == S_LP);
  assign busy = !((state_q == S_DA) ||
                  (state_q == S_LD));
  assign pkt_drop = drop_q;

endmodule

// File: doc/router_pkt_ctrl.md
Name: router_pkt_ctrl

Overview:
- Packet-reception controller for the 1x3 router.
- Sequences header decode, payload load, FIFO-full stall and parity check for each incoming packet.
- Drives the enables consumed by the register block and the synchroniser (detect_add, write_en_reg, lfd/ld/laf/full states).
- Aborts a packet on soft reset of its destination port, or when the destination FIFO stays occupied past a timeout.

Parameters:
- WAIT_LIMIT, 64: max cycles spent in WAIT_TILL_EMPTY before the packet is dropped; 0 disables the timeout.
- CNT_W, 7: width of the wait counter; must satisfy 2^CNT_W > WAIT_LIMIT.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- pkt_valid  input  1  source is driving a valid packet byte
- data_in  input  2  destination address, data[1:0] of the header byte; 2'b11 is invalid
- fifo_full  input  1  selected destination FIFO full (from synchroniser)
- fifo_empty_0/1/2  input  1 each  per-port FIFO empty
- soft_reset_0/1/2  input  1 each  per-port soft reset (from synchroniser)
- parity_done  input  1  register block has captured the parity byte
- low_pkt_valid  input  1  pkt_valid dropped while stalled in FIFO_FULL
- detect_add  output  1  controller is in DECODE_ADDRESS
- lfd_state  output  1  load first data (header) cycle
- ld_state  output  1  payload load cycle
- laf_state  output  1  load-after-full cycle
- full_state  output  1  stalled on full FIFO
- write_en_reg  output  1  FIFO write request to synchroniser
- rst_int_reg  output  1  clear internal parity registers
- busy  output  1  source must hold its current byte
- pkt_drop  output  1  one-cycle pulse when a packet is abandoned

Behaviour:
- States: DA (DECODE_ADDRESS), LFD, LD, FFS (FIFO_FULL_STATE), LAF, LP (LOAD_PARITY), CPE (CHECK_PARITY_ERROR), WTE (WAIT_TILL_EMPTY).
- Reset (async, rst=1):
  - state=DA, latched addr=0, wait counter=0.
  - Outputs: detect_add=1; all other outputs 0.
- Outputs are Moore-decoded from registered state; no combinational input-to-output paths. The one exception is pkt_drop, which is registered.
  - detect_add=DA; lfd_state=LFD; ld_state=LD; laf_state=LAF; full_state=FFS; rst_int_reg=CPE.
  - write_en_reg = LFD|LD|LAF|LP.
  - busy = LFD|FFS|LAF|LP|CPE|WTE. busy is 0 in DA and LD.
- Address latch:
  - addr <= data_in on the DA edge where pkt_valid=1 and data_in!=2'b11.
  - The latched addr selects fifo_empty_N and soft_reset_N in every later state.
- Transitions (evaluated each rising clk edge):
  - DA: pkt_valid=1 and data_in!=3 → LFD if fifo_empty[data_in]=1, else WTE. Otherwise stay in DA; data_in=3 is ignored.
  - LFD → LD unconditionally.
  - LD: fifo_full → FFS; else pkt_valid=0 → LP; else stay in LD. fifo_full takes priority over pkt_valid.
  - FFS: fifo_full=0 → LAF; else stay in FFS.
  - LAF: parity_done=1 → DA; else low_pkt_valid=1 → LP; else → LD.
  - LP → CPE unconditionally.
  - CPE: fifo_full → FFS; else → DA.
  - WTE:
    - fifo_empty[addr]=1 → LFD, counter cleared.
    - Otherwise the counter increments. If WAIT_LIMIT!=0 and counter==WAIT_LIMIT-1 → DA, with pkt_drop=1 for the following cycle. Empty wins over timeout on the same edge.
- Soft reset:
  - In any state other than DA, soft_reset[addr]=1 → DA next edge, pkt_drop=1, counter cleared.
  - Soft reset has priority over every other transition. Soft resets of non-selected ports are ignored.
- Counter: non-zero only in WTE; cleared on every exit from WTE. Saturates rather than wrapping when WAIT_LIMIT=0.
- Reset mid-packet: returns to DA immediately (asynchronous). No pkt_drop pulse is generated on reset.

Test Plan:
- Reset: assert rst mid-LD → same-cycle detect_add=1, write_en_reg=0, busy=0; after release, state DA.
- Normal packet: DA with pkt_valid=1, data_in=2'b01, fifo_empty_1=1 → LFD (write_en_reg=1, busy=1), then LD for 3 bytes, pkt_valid=0 → LP, CPE (rst_int_reg=1), DA; exactly 5 write_en_reg cycles for 3 payload bytes.
- Full stall: in LD raise fifo_full for 4 cycles → full_state=1 and write_en_reg=0 for 4 cycles; drop fifo_full → LAF for one cycle; low_pkt_valid=1 → LP.
- Busy destination: data_in=2'b10, fifo_empty_2=0 → WTE, busy=1; fifo_empty_2=1 after 10 cycles → LFD on the next edge, pkt_drop stays 0.
- Timeout: WAIT_LIMIT=8, fifo_empty_0 held 0 → exactly 8 cycles in WTE, then DA with pkt_drop=1 for one cycle.
- Soft reset and invalid address: soft_reset_1 during LD to port 1 → DA next edge, pkt_drop=1; soft_reset_2 during the same packet → ignored; data_in=2'b11 with pkt_valid=1 → remains in DA, detect_add=1.
